onehot_pulse_decoder: RTL and testbench
=======================================

// Module: onehot_pulse_decoder
// PURPOSE
//   Inverse of the 8:3 priority encoder path: consumes an encoded index plus
//   valid over a valid/ready handshake and re-expands it to a one-hot strobe.
//   The strobe is held for a fixed pulse length, then a guard gap follows
//   before the next index is accepted.
//   Sits on the request-return side and drives per-line grant/strobe wires.
// PARAMETERS
//   IDX_W      3   width of encoded index input
//   OUT_W      8   number of one-hot output lines; legal 1..2**IDX_W
//   PULSE_CYC  4   cycles the one-hot strobe stays asserted; legal >=1
//   GAP_CYC    1   idle guard cycles after each pulse; legal >=0
//   CNT_W      8   width of saturating accept/error counters
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       async active-low reset
//   in_code    in   IDX_W   encoded index (e.g. encoder out)
//   in_v       in   1       index valid (e.g. encoder v)
//   in_rdy     out  1       block ready to accept
//   out        out  OUT_W   registered one-hot strobe, all-zero when idle
//   out_v      out  1       high while out carries a strobe
//   err        out  1       1-cycle pulse: accepted code >= OUT_W
//   busy       out  1       state != IDLE
//   acc_cnt    out  CNT_W   accepted transfers, saturating
//   err_cnt    out  CNT_W   out-of-range codes, saturating
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, out=0, out_v=0, err=0,
//     counters=0, internal cycle counter=0. Reset mid-pulse kills out at once.
//   - in_rdy = (state==IDLE), decoded from state regs; no combinational path
//     from in_v to in_rdy. Transfer = in_v & in_rdy at a rising edge.
//   - States: IDLE -> PULSE -> GAP -> IDLE. GAP skipped when GAP_CYC==0
//     (PULSE -> IDLE). No state is ever entered without a transfer.
//   - Transfer at edge k, in_code < OUT_W: at edge k, state<=PULSE,
//     out<=(1<<in_code), out_v<=1. Strobe visible cycles k+1..k+PULSE_CYC.
//     out/out_v cleared at edge k+PULSE_CYC; then GAP_CYC cycles with out=0.
//     in_rdy high again from cycle k+1+PULSE_CYC+GAP_CYC. Max throughput:
//     1 transfer per (1+PULSE_CYC+GAP_CYC) cycles.
//   - Transfer with in_code >= OUT_W: accepted (consumed), out stays 0,
//     err pulses for exactly cycle k+1, err_cnt increments, state goes
//     straight to GAP (or IDLE if GAP_CYC==0); acc_cnt not incremented.
//   - acc_cnt increments on each in-range transfer; both counters hold at
//     2**CNT_W-1 (no wrap).
//   - in_v while in_rdy=0: ignored, not queued; in_code don't-care when
//     in_v=0. Upstream must hold in_v/in_code until handshake completes.
//   - out is always zero or exactly one-hot; out_v == |out.
//   - Cycle counter counts 0..PULSE_CYC-1 in PULSE, 0..GAP_CYC-1 in GAP,
//     cleared on each state change.
// TESTING
//   1 reset: rst_n=0 mid-PULSE (code 5) -> out=0, out_v=0, in_rdy=1, counters=0
//     asynchronously, before the next clock edge.
//   2 single: in_code=3,in_v=1 at edge k -> out=8'h08 cycles k+1..k+4,
//     in_rdy=0 k+1..k+5, in_rdy=1 at k+6, acc_cnt=1.
//   3 back-to-back: in_v held high, codes 0,7 -> 8'h01 then 8'h80, strobes
//     separated by exactly GAP_CYC=1 zero cycle; code 7 accepted only on the
//     edge where in_rdy=1.
//   4 out-of-range: OUT_W=6, in_code=6 -> out stays 0, err=1 one cycle,
//     err_cnt=1, acc_cnt unchanged, in_rdy back after GAP_CYC.
//   5 GAP_CYC=0, PULSE_CYC=1: codes 1,2 streamed -> 8'h02,0,8'h04 pattern,
//     one transfer per 2 cycles.
//   6 saturation: CNT_W=2, 5 valid transfers -> acc_cnt sticks at 3;
//     encoder->decoder loopback over all 256 inputs: out == MSB one-hot
//     of the input, no strobe when encoder v=0.

Source files
------------

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: re-expands an encoded index into a timed one-hot strobe followed by a guard gap
module onehot_pulse_decoder #(
  parameter int IDX_W     = 3,
  parameter int OUT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] in_code,
  input  logic             in_v,
  output logic             in_rdy,
  output logic [OUT_W-1:0] out,
  output logic             out_v,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  localparam int CMAX = PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [IDX_W:0] OUT_LIM = (IDX_W+1)'(OUT_W);
  localparam state_t POST = GAP_CYC == 0 ? IDLE : GAP;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [OUT_W-1:0] out_n;
  logic xfer, in_range, last, err_n, acc_inc;
  assign in_rdy   = state == IDLE;
  assign busy     = state != IDLE;
  assign xfer     = in_v & in_rdy;
  assign in_range = {1'b0, in_code} < OUT_LIM;
  assign last     = cnt == CW'(state == PULSE ? PULSE_CYC - 1 : GAP_CYC - 1);
  // state register and per-state cycle counter, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end
  // next state: out-of-range codes skip the strobe and go straight to the gap
  always_comb begin
    state_n = (state == IDLE)  ? (xfer ? (in_range ? PULSE : POST) : IDLE) :
              (state == PULSE) ? (last ? POST : PULSE) :
                                 (last ? IDLE : GAP);
  end
  // next outputs: load the strobe on entry to PULSE, hold it, zero it elsewhere
  always_comb begin
    out_n   = (state_n == PULSE) ? (state == IDLE ? OUT_W'(1) << in_code : out) : '0;
    err_n   = xfer & ~in_range;
    acc_inc = xfer & in_range;
  end
  // registered outputs and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      out_v   <= 1'b0;
      err     <= 1'b0;
      acc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      out     <= out_n;
      out_v   <= |out_n;
      err     <= err_n;
      acc_cnt <= acc_cnt + CNT_W'(acc_inc && acc_cnt != '1);
      err_cnt <= err_cnt + CNT_W'(err_n && err_cnt != '1);
    end
  end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: directed checks of strobe timing, gap, error path, saturation and encoder loopback
module tb_onehot_pulse_decoder;
  logic clk = 0;
  logic rst_n = 1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic [2:0] a_code = 0, b_code = 0, c_code = 0, d_code = 0;
  logic a_v = 0, b_v = 0, c_v = 0, d_v = 0;
  logic a_rdy, b_rdy, c_rdy, d_rdy, a_ov, b_ov, c_ov, d_ov;
  logic a_err, b_err, c_err, d_err, a_busy, b_busy, c_busy, d_busy;
  logic [7:0] a_out, c_out, d_out, a_acc, a_ec, b_acc, b_ec, c_acc, c_ec;
  logic [5:0] b_out;
  logic [1:0] d_acc, d_ec;

  onehot_pulse_decoder u_a (.clk(clk), .rst_n(rst_n), .in_code(a_code), .in_v(a_v), .in_rdy(a_rdy),
    .out(a_out), .out_v(a_ov), .err(a_err), .busy(a_busy), .acc_cnt(a_acc), .err_cnt(a_ec));
  onehot_pulse_decoder #(.OUT_W(6)) u_b (.clk(clk), .rst_n(rst_n), .in_code(b_code), .in_v(b_v), .in_rdy(b_rdy),
    .out(b_out), .out_v(b_ov), .err(b_err), .busy(b_busy), .acc_cnt(b_acc), .err_cnt(b_ec));
  onehot_pulse_decoder #(.PULSE_CYC(1), .GAP_CYC(0)) u_c (.clk(clk), .rst_n(rst_n), .in_code(c_code), .in_v(c_v),
    .in_rdy(c_rdy), .out(c_out), .out_v(c_ov), .err(c_err), .busy(c_busy), .acc_cnt(c_acc), .err_cnt(c_ec));
  onehot_pulse_decoder #(.CNT_W(2)) u_d (.clk(clk), .rst_n(rst_n), .in_code(d_code), .in_v(d_v), .in_rdy(d_rdy),
    .out(d_out), .out_v(d_ov), .err(d_err), .busy(d_busy), .acc_cnt(d_acc), .err_cnt(d_ec));

  task automatic test_reset();
    checks++; if (a_rdy !== 1'b1 || a_out !== 8'h00 || a_acc !== 8'd0 || a_ec !== 8'd0) begin
      errors++; $display("FAIL reset_idle: rdy=%b out=%h acc=%0d ec=%0d want 1 00 0 0", a_rdy, a_out, a_acc, a_ec);
    end
    @(negedge clk); a_code = 3'd5; a_v = 1;
    @(posedge clk);
    @(negedge clk); a_v = 0;
    @(negedge clk);
    checks++; if (a_out !== 8'h20) begin errors++; $display("FAIL reset_prepulse: out=%h want 20", a_out); end
    #1 rst_n = 0;
    #1;
    checks++; if (a_out !== 8'h00 || a_ov !== 1'b0) begin
      errors++; $display("FAIL reset_kill: out=%h out_v=%b want 00 0", a_out, a_ov);
    end
    checks++; if (a_rdy !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL reset_state: rdy=%b busy=%b want 1 0", a_rdy, a_busy);
    end
    checks++; if (a_acc !== 8'd0 || a_ec !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: acc=%0d ec=%0d want 0 0", a_acc, a_ec);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_single();
    @(negedge clk); a_code = 3'd3; a_v = 1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); a_v = 0;
      checks++; if (a_out !== (i <= 4 ? 8'h08 : 8'h00) || a_ov !== (i <= 4)) begin
        errors++; $display("FAIL single_out c%0d: out=%h v=%b want %h", i, a_out, a_ov, i <= 4 ? 8'h08 : 8'h00);
      end
      checks++; if (a_rdy !== (i >= 6)) begin
        errors++; $display("FAIL single_rdy c%0d: rdy=%b want %b", i, a_rdy, i >= 6);
      end
    end
    checks++; if (a_acc !== 8'd1) begin errors++; $display("FAIL single_acc: acc=%0d want 1", a_acc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_out [1:12];
    logic exp_rdy [1:12];
    exp_out = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
    exp_rdy = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    @(negedge clk); a_code = 3'd0; a_v = 1;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++; if (a_out !== exp_out[i] || a_rdy !== exp_rdy[i]) begin
        errors++; $display("FAIL b2b c%0d: out=%h rdy=%b want %h %b", i, a_out, a_rdy, exp_out[i], exp_rdy[i]);
      end
      if (i == 1) a_code = 3'd7;
      if (i == 7) a_v = 0;
    end
    checks++; if (a_acc !== 8'd3) begin errors++; $display("FAIL b2b_acc: acc=%0d want 3", a_acc); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk); b_code = 3'd6; b_v = 1;
    @(posedge clk);
    @(negedge clk); b_v = 0;
    checks++; if (b_out !== 6'h00 || b_ov !== 1'b0 || b_err !== 1'b1) begin
      errors++; $display("FAIL oor_c1: out=%h v=%b err=%b want 00 0 1", b_out, b_ov, b_err);
    end
    checks++; if (b_ec !== 8'd1 || b_acc !== 8'd0 || b_rdy !== 1'b0) begin
      errors++; $display("FAIL oor_cnt: ec=%0d acc=%0d rdy=%b want 1 0 0", b_ec, b_acc, b_rdy);
    end
    @(negedge clk);
    checks++; if (b_err !== 1'b0 || b_rdy !== 1'b1 || b_out !== 6'h00) begin
      errors++; $display("FAIL oor_c2: err=%b rdy=%b out=%h want 0 1 00", b_err, b_rdy, b_out);
    end
    b_code = 3'd5; b_v = 1;
    @(posedge clk);
    @(negedge clk); b_v = 0;
    checks++; if (b_out !== 6'h20 || b_err !== 1'b0 || b_acc !== 8'd1 || b_ec !== 8'd1) begin
      errors++; $display("FAIL oor_inrange: out=%h err=%b acc=%0d ec=%0d want 20 0 1 1", b_out, b_err, b_acc, b_ec);
    end
  endtask

  task automatic test_no_gap();
    logic [7:0] exp_out [1:4];
    logic exp_rdy [1:4];
    exp_out = '{8'h02, 8'h00, 8'h04, 8'h00};
    exp_rdy = '{0, 1, 0, 1};
    @(negedge clk); c_code = 3'd1; c_v = 1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (c_out !== exp_out[i] || c_rdy !== exp_rdy[i]) begin
        errors++; $display("FAIL nogap c%0d: out=%h rdy=%b want %h %b", i, c_out, c_rdy, exp_out[i], exp_rdy[i]);
      end
      if (i == 1) c_code = 3'd2;
      if (i == 3) c_v = 0;
    end
    checks++; if (c_acc !== 8'd2) begin errors++; $display("FAIL nogap_acc: acc=%0d want 2", c_acc); end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 5; n++) begin
      for (int t = 0; t < 12 && !d_rdy; t++) @(negedge clk);
      checks++; if (d_rdy !== 1'b1) begin errors++; $display("FAIL sat_wait n%0d: rdy=%b want 1", n, d_rdy); end
      d_code = 3'(n); d_v = 1;
      @(posedge clk);
      @(negedge clk); d_v = 0;
      checks++; if (d_acc !== 2'(n > 3 ? 3 : n)) begin
        errors++; $display("FAIL sat_acc n%0d: acc=%0d want %0d", n, d_acc, n > 3 ? 3 : n);
      end
    end
  endtask

  task automatic test_loopback();
    logic [2:0] enc;
    logic [7:0] x, exp;
    logic v;
    for (int k = 0; k < 256; k++) begin
      x = 8'(k);
      enc = 0; exp = 0; v = |x;
      for (int j = 0; j < 8; j++) if (x[j]) enc = 3'(j);
      for (int j = 7; j >= 0; j--) if (x[j] && exp == 0) exp[j] = 1'b1;
      for (int t = 0; t < 12 && !a_rdy; t++) @(negedge clk);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL loop_wait x=%h: rdy=%b want 1", x, a_rdy); end
      a_code = enc; a_v = v;
      @(posedge clk);
      @(negedge clk); a_v = 0;
      checks++; if (a_out !== exp || a_ov !== v) begin
        errors++; $display("FAIL loop x=%h: out=%h v=%b want %h %b", x, a_out, a_ov, exp, v);
      end
    end
  endtask

  initial begin
    #1 rst_n = 0;
    #12;
    @(negedge clk); rst_n = 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_no_gap();
    test_saturation();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
